// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART TX scheduler: FSM encoding, grant width, sizing helper.
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_t;

  localparam int GRANT_W = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr.sv
// Combinational round-robin pick: first requester at or after ptr_i, modulo NUM_REQ.
module rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [GRANT_W-1:0] idx_o,
  output logic               any_o
);

  int best_d;
  int d;

  // Distance from the pointer decides priority; smallest distance wins.
  always_comb begin
    best_d = NUM_REQ;
    d      = 0;
    idx_o  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_i[i]) begin
        d = i - int'(ptr_i);
        if (d < 0) d = d + NUM_REQ;
        if (d < best_d) begin
          best_d = d;
          idx_o  = GRANT_W'(i);
        end
      end
    end
    any_o = (best_d < NUM_REQ);
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_o[i] = any_o && (idx_o == GRANT_W'(i));
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX byte serializer between NUM_REQ message sources with
// message-granular round-robin, an inter-message gap and a stall watchdog.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 270,
  parameter int TIMEOUT    = 2700
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [GRANT_W-1:0]     grant_id,
  output logic                   busy,
  output logic                   abort,
  output sched_state_t           dbg_state
);

  localparam int CNT_W    = $clog2(max_int(GAP_CYCLES, TIMEOUT) + 1);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Handshake: a byte moves on a cycle where valid and ready are both high;
  // a source must hold valid/data/last stable until that cycle.
  sched_state_t       state_q, state_d;
  logic [GRANT_W-1:0] grant_id_q, grant_id_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic               busy_q, busy_d;
  logic               abort_q, abort_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [GRANT_W-1:0] arb_idx;
  logic               arb_any;

  logic               own_valid, own_last, send, xfer, release_msg;
  logic [7:0]         own_data;
  logic [GRANT_W-1:0] next_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == GRANT_W'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  assign send     = (state_q == ST_SEND);
  assign xfer     = send && own_valid && tx_ready;
  assign tx_valid = send && own_valid;
  assign tx_data  = send ? own_data : 8'h00;
  assign next_ptr = (grant_id_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id_q + GRANT_W'(1);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = send && tx_ready && (grant_id_q == GRANT_W'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    busy_d      = busy_q;
    abort_d     = 1'b0;
    cnt_d       = cnt_q;
    release_msg = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_id_d = arb_idx;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          cnt_d       = '0;
          release_msg = own_last;
        end else if (!own_valid) begin
          // Watchdog only advances while the owner is starving the serializer.
          if (cnt_q == CNT_W'(TO_LAST)) begin
            abort_d     = 1'b1;
            release_msg = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (release_msg) begin
          rr_ptr_d = next_ptr;
          cnt_d    = '0;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_LAST)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
      cnt_q      <= cnt_d;
    end
  end

  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign abort     = abort_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: arbitration, gap, back-pressure, watchdog, reset.
module tb_uart_tx_scheduler;
  import uart_tx_scheduler_pkg::*;

  localparam int NR     = 2;
  localparam int GAP    = 4;
  localparam int TO     = 20;
  localparam int BUDGET = 500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic            src_valid [NR];
  logic [7:0]      src_data  [NR];
  logic            src_last  [NR];
  logic [NR-1:0]   req_valid, req_last, req_ready;
  logic [8*NR-1:0] req_data;
  logic            tx_valid, tx_ready, busy, abort;
  logic [7:0]      tx_data;
  logic [2:0]      grant_id;
  sched_state_t    dbg_state;

  logic [NR-1:0]   z_req_valid, z_req_last, z_req_ready;
  logic [8*NR-1:0] z_req_data;
  logic            z_tx_valid, z_tx_ready, z_busy, z_abort;
  logic [7:0]      z_tx_data;
  logic [2:0]      z_grant_id;
  sched_state_t    z_dbg_state;

  assign req_valid = {src_valid[1], src_valid[0]};
  assign req_last  = {src_last[1], src_last[0]};
  assign req_data  = {src_data[1], src_data[0]};

  uart_tx_scheduler #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy),
    .abort(abort), .dbg_state(dbg_state)
  );

  uart_tx_scheduler #(.NUM_REQ(NR), .GAP_CYCLES(0), .TIMEOUT(TO)) dut_z (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_data(z_req_data),
    .req_last(z_req_last), .req_ready(z_req_ready), .tx_valid(z_tx_valid),
    .tx_data(z_tx_data), .tx_ready(z_tx_ready), .grant_id(z_grant_id), .busy(z_busy),
    .abort(z_abort), .dbg_state(z_dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] exp_q[$];
  int abort_cnt = 0;
  int abort_lat = 0;
  int last_xfer_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every byte handed to the serializer, tagged with its owner
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      last_xfer_cyc = cyc;
      if (exp_q.size() == 0) chk("sb_extra_byte", 32'(exp_q.size()), 1);
      else chk("sb_byte", {21'd0, grant_id, tx_data}, {21'd0, exp_q.pop_front()});
    end
    if (rst_n && abort) begin
      abort_cnt++;
      abort_lat = cyc - last_xfer_cyc;
    end
  end

  // driver: presents n bytes from source s, last flagged on final byte when end_msg
  task automatic send_bytes(input int s, input int n, input logic [7:0] base, input bit end_msg);
    for (int b = 0; b < n; b++) begin
      int waited = 0;
      bit got = 0;
      src_valid[s] = 1'b1;
      src_data[s]  = base + 8'(b);
      src_last[s]  = end_msg && (b == n - 1);
      while (!got && waited < BUDGET) begin
        @(negedge clk);
        if (req_ready[s]) got = 1;
        @(posedge clk); #1;
        waited++;
      end
      chk("byte_accept_timeout", 32'(got), 1);
    end
    src_valid[s] = 1'b0;
    src_last[s]  = 1'b0;
    src_data[s]  = 8'h00;
  endtask

  task automatic wait_idle();
    int waited = 0;
    bit done = 0;
    while (!done && waited < BUDGET) begin
      @(negedge clk);
      if (!busy) done = 1;
      waited++;
    end
    chk("idle_timeout", 32'(done), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit seen, v_bad, d_bad, a_bad;
    for (int i = 0; i < NR; i++) begin
      src_valid[i] = 1'b0; src_data[i] = 8'h00; src_last[i] = 1'b0;
    end
    tx_ready = 1'b1;
    z_req_valid = '0; z_req_last = '0; z_req_data = '0; z_tx_ready = 1'b1;

    // reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_abort", 32'(abort), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // src0: A1 A2 A3, one idle arbitration cycle, then gap of GAP cycles
    exp_q.push_back({3'd0, 8'hA1}); exp_q.push_back({3'd0, 8'hA2}); exp_q.push_back({3'd0, 8'hA3});
    fork
      send_bytes(0, 3, 8'hA1, 1);
      begin
        @(negedge clk);
        chk("arb_cycle_tx_valid", 32'(tx_valid), 0);
        chk("arb_cycle_busy", 32'(busy), 0);
        @(negedge clk);
        chk("send_busy", 32'(busy), 1);
        chk("send_grant", 32'(grant_id), 0);
      end
    join
    chk("gap_tx_valid", 32'(tx_valid), 0);
    chk("gap_tx_data", 32'(tx_data), 0);
    repeat (GAP - 1) @(posedge clk);
    #1;
    chk("gap_busy_held", 32'(busy), 1);
    @(posedge clk); #1;
    chk("gap_busy_released", 32'(busy), 0);

    // single-byte from src1 brings rr_ptr back to 0
    exp_q.push_back({3'd1, 8'hC1});
    send_bytes(1, 1, 8'hC1, 1);
    wait_idle();

    // tie with rr_ptr=0: src0 message first, then src1; next tie src0 again
    exp_q.push_back({3'd0, 8'h31}); exp_q.push_back({3'd0, 8'h32});
    exp_q.push_back({3'd1, 8'h41}); exp_q.push_back({3'd1, 8'h42});
    fork
      send_bytes(0, 2, 8'h31, 1);
      send_bytes(1, 2, 8'h41, 1);
    join
    wait_idle();
    exp_q.push_back({3'd0, 8'h51}); exp_q.push_back({3'd1, 8'h61});
    fork
      send_bytes(0, 1, 8'h51, 1);
      send_bytes(1, 1, 8'h61, 1);
    join
    wait_idle();

    // back-pressure: tx_ready low 50 cycles while D2 is presented
    exp_q.push_back({3'd0, 8'hD1}); exp_q.push_back({3'd0, 8'hD2}); exp_q.push_back({3'd0, 8'hD3});
    v_bad = 0; d_bad = 0; a_bad = 0; seen = 0;
    fork
      send_bytes(0, 3, 8'hD1, 1);
      begin
        for (int k = 0; k < BUDGET && !seen; k++) begin
          @(negedge clk);
          if (tx_valid && tx_data == 8'hD1) seen = 1;
        end
        chk("d1_seen", 32'(seen), 1);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (tx_valid !== 1'b1) v_bad = 1;
          if (tx_data !== 8'hD2) d_bad = 1;
          if (abort !== 1'b0) a_bad = 1;
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
      end
    join
    chk("hold_tx_valid", 32'(v_bad), 0);
    chk("hold_tx_data", 32'(d_bad), 0);
    chk("hold_no_abort", 32'(a_bad), 0);
    wait_idle();

    // watchdog: src0 stalls after E1, src1 waiting gets the serializer after abort
    exp_q.push_back({3'd0, 8'hE1}); exp_q.push_back({3'd1, 8'hF1});
    fork
      send_bytes(0, 1, 8'hE1, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        send_bytes(1, 1, 8'hF1, 1);
      end
    join
    wait_idle();
    chk("abort_count", 32'(abort_cnt), 1);
    chk("abort_latency", 32'(abort_lat), TO + 1);

    // GAP_CYCLES=0: two always-pending single-byte sources alternate with one idle cycle between
    z_req_valid = 2'b11; z_req_last = 2'b11; z_req_data = {8'hC3, 8'h5A};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("z_idle_tx_valid", 32'(z_tx_valid), 0);
        chk("z_idle_tx_data", 32'(z_tx_data), 0);
        chk("z_idle_busy", 32'(z_busy), 0);
      end else begin
        chk("z_send_tx_valid", 32'(z_tx_valid), 1);
        chk("z_send_tx_data", 32'(z_tx_data), ((k % 4) == 1) ? 32'h5A : 32'hC3);
        chk("z_send_grant", 32'(z_grant_id), ((k % 4) == 1) ? 0 : 1);
        chk("z_send_busy", 32'(z_busy), 1);
      end
    end
    @(posedge clk); #1;
    z_req_valid = '0; z_req_last = '0;

    // rr_ptr -> 1, then reset during byte 2 of a src1 message
    exp_q.push_back({3'd0, 8'h81});
    send_bytes(0, 1, 8'h81, 1);
    wait_idle();
    exp_q.push_back({3'd1, 8'h71});
    src_valid[1] = 1'b1; src_data[1] = 8'h71; src_last[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    src_data[1] = 8'h72;
    tx_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    chk("mid_rst_grant", 32'(grant_id), 0);
    src_valid[1] = 1'b0; src_data[1] = 8'h00;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({3'd0, 8'h91}); exp_q.push_back({3'd1, 8'h92});
    fork
      send_bytes(0, 1, 8'h91, 1);
      send_bytes(1, 1, 8'h92, 1);
    join
    wait_idle();

    chk("sb_empty", 32'(exp_q.size()), 0);
    chk("abort_total", 32'(abort_cnt), 1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
